// File: rtl/uart_io_pio_pkg.sv
// Shared definitions for the UART_IO parallel I/O blocks: register map
// addresses and the edge-capture mode encoding.
package uart_io_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Debounce counter width; never zero so the bypass build still elaborates.
    function automatic int deb_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_io_pio_debounce.sv
// One input bit: synchroniser chain into clk, then either a stable-count
// debouncer or a single register stage when debouncing is disabled.
module uart_io_pio_debounce
    import uart_io_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb <= 1'b0;
                end else begin
                    deb <= sync;
                end
            end
        end else begin : g_debounce
            localparam int CNT_W = deb_cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // Any return of sync to the accepted level restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (sync == deb) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    deb <= sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_io_pio_in.sv
// Avalon-MM input PIO: synchronised/debounced inputs, sticky edge capture
// with write-1-to-clear, per-bit interrupt mask and registered read data.
module uart_io_pio_in
    import uart_io_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic             chipselect,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            uart_io_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .async_in (in_port[i]),
                .deb      (deb[i])
            );
        end
    endgenerate

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= deb;
        end
    end

    assign rise = deb & ~prev;
    assign fall = ~deb & prev;

    always_comb begin
        edge_sel = rise;
        case (EDGE_SEL)
            EDGE_RISE: edge_sel = rise;
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = rise;
        endcase
    end

    assign wr_en     = chipselect & ~write_n;
    assign cap_clear = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == PIO_ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // A newly detected edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clear) | edge_sel;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = deb;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_uart_io_pio_in.sv
// Directed bench for uart_io_pio_in: four configurations share one bus,
// selected per instance by chipselect.
module tb_uart_io_pio_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c, cs_d;
    logic [1:0]  in_a, in_b, in_c;
    logic [31:0] in_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic        irq_a, irq_b, irq_c, irq_d;

    int checks;
    int failures;

    // a: bypass rising, b: debounce 8, c: bypass falling, d: 32-bit any edge
    uart_io_pio_in #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .chipselect(cs_a), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a));

    uart_io_pio_in #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .chipselect(cs_b), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b));

    uart_io_pio_in #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .chipselect(cs_c), .writedata(writedata), .in_port(in_c),
        .readdata(rd_c), .irq(irq_c));

    uart_io_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_d (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .chipselect(cs_d), .writedata(writedata), .in_port(in_d),
        .readdata(rd_d), .irq(irq_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int dut, input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        cs_a      = (dut == 0);
        cs_b      = (dut == 1);
        cs_c      = (dut == 2);
        cs_d      = (dut == 3);
        tick(1);
        write_n   = 1'b1;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        cs_c      = 1'b0;
        cs_d      = 1'b0;
        writedata = 32'h0;
    endtask

    task automatic test_reset();
        address = 2'd0;
        tick(1);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", rd_a, 32'h0); end
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_mask got=%h exp=%h", rd_a, 32'h0); end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_edgecap got=%h exp=%h", rd_a, 32'h0); end
        checks++;
        if ({irq_a, irq_b, irq_c, irq_d} !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_irq got=%b exp=%b", {irq_a, irq_b, irq_c, irq_d}, 4'b0000);
        end
    endtask

    task automatic test_bypass_rise();
        address = 2'd0;
        in_a    = 2'b01;
        tick(3);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL bypass_data_early got=%h exp=%h", rd_a, 32'h0); end
        tick(1);
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("[TB] FAIL bypass_data got=%h exp=%h", rd_a, 32'h1); end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("[TB] FAIL bypass_edgecap got=%h exp=%h", rd_a, 32'h1); end
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("[TB] FAIL bypass_irq_masked got=%b exp=%b", irq_a, 1'b0); end
        bus_write(0, 2'd2, 32'h1);
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("[TB] FAIL bypass_irq_unmasked got=%b exp=%b", irq_a, 1'b1); end
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("[TB] FAIL bypass_mask_read got=%h exp=%h", rd_a, 32'h1); end
    endtask

    task automatic test_irq_clear();
        bus_write(0, 2'd3, 32'h1);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("[TB] FAIL clear_irq got=%b exp=%b", irq_a, 1'b0); end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL clear_edgecap got=%h exp=%h", rd_a, 32'h0); end
        in_a = 2'b11;
        tick(6);
        checks++;
        if (rd_a !== 32'h2) begin failures++; $display("[TB] FAIL clear_bit1_capture got=%h exp=%h", rd_a, 32'h2); end
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("[TB] FAIL clear_bit1_irq got=%b exp=%b", irq_a, 1'b0); end
        bus_write(0, 2'd3, 32'h0);
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_a !== 32'h2) begin failures++; $display("[TB] FAIL clear_write0_holds got=%h exp=%h", rd_a, 32'h2); end
        bus_write(0, 2'd0, 32'hFFFF_FFFF);
        bus_write(0, 2'd1, 32'hFFFF_FFFF);
        address = 2'd0;
        tick(1);
        checks++;
        if (rd_a !== 32'h3) begin failures++; $display("[TB] FAIL data_write_ignored got=%h exp=%h", rd_a, 32'h3); end
        address = 2'd1;
        tick(1);
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("[TB] FAIL reserved_read got=%h exp=%h", rd_a, 32'h0); end
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("[TB] FAIL mask_unchanged got=%h exp=%h", rd_a, 32'h1); end
    endtask

    task automatic test_debounce();
        address = 2'd0;
        in_b    = 2'b10;
        tick(5);
        in_b    = 2'b00;
        tick(12);
        checks++;
        if (rd_b !== 32'h0) begin failures++; $display("[TB] FAIL deb_pulse_data got=%h exp=%h", rd_b, 32'h0); end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_b !== 32'h0) begin failures++; $display("[TB] FAIL deb_pulse_edgecap got=%h exp=%h", rd_b, 32'h0); end
        address = 2'd0;
        in_b    = 2'b10;
        tick(10);
        checks++;
        if (rd_b !== 32'h0) begin failures++; $display("[TB] FAIL deb_data_early got=%h exp=%h", rd_b, 32'h0); end
        tick(1);
        checks++;
        if (rd_b !== 32'h2) begin failures++; $display("[TB] FAIL deb_data_latency got=%h exp=%h", rd_b, 32'h2); end
        address = 2'd3;
        tick(2);
        checks++;
        if (rd_b !== 32'h2) begin failures++; $display("[TB] FAIL deb_edgecap got=%h exp=%h", rd_b, 32'h2); end
    endtask

    task automatic test_falling();
        address = 2'd3;
        in_c    = 2'b01;
        tick(6);
        checks++;
        if (rd_c !== 32'h0) begin failures++; $display("[TB] FAIL fall_rise_ignored got=%h exp=%h", rd_c, 32'h0); end
        in_c = 2'b00;
        tick(6);
        checks++;
        if (rd_c !== 32'h1) begin failures++; $display("[TB] FAIL fall_capture got=%h exp=%h", rd_c, 32'h1); end
        in_c = 2'b01;
        tick(6);
        in_c = 2'b00;
        tick(3);
        bus_write(2, 2'd3, 32'h1);
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_c !== 32'h1) begin failures++; $display("[TB] FAIL fall_set_beats_clear got=%h exp=%h", rd_c, 32'h1); end
        bus_write(2, 2'd3, 32'h1);
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_c !== 32'h0) begin failures++; $display("[TB] FAIL fall_clear got=%h exp=%h", rd_c, 32'h0); end
    endtask

    task automatic test_any_width32();
        address = 2'd0;
        in_d    = 32'hFFFF_FFFF;
        tick(9);
        checks++;
        if (rd_d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL w32_data got=%h exp=%h", rd_d, 32'hFFFF_FFFF); end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL w32_rise_cap got=%h exp=%h", rd_d, 32'hFFFF_FFFF); end
        bus_write(3, 2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_d !== 32'h0) begin failures++; $display("[TB] FAIL w32_clear got=%h exp=%h", rd_d, 32'h0); end
        in_d = 32'h0;
        tick(10);
        checks++;
        if (rd_d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL w32_fall_cap got=%h exp=%h", rd_d, 32'hFFFF_FFFF); end
        bus_write(3, 2'd2, 32'h0000_0001);
        checks++;
        if (irq_d !== 1'b1) begin failures++; $display("[TB] FAIL w32_irq got=%b exp=%b", irq_d, 1'b1); end
    endtask

    task automatic test_reset_mid_debounce();
        in_d = 32'h0000_00FF;
        tick(4);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq_d !== 1'b0) begin failures++; $display("[TB] FAIL rst_irq got=%b exp=%b", irq_d, 1'b0); end
        checks++;
        if (rd_d !== 32'h0 || rd_a !== 32'h0) begin
            failures++; $display("[TB] FAIL rst_readdata got=%h/%h exp=%h", rd_d, rd_a, 32'h0);
        end
        tick(2);
        reset_n = 1'b1;
        address = 2'd0;
        tick(6);
        checks++;
        if (rd_d !== 32'h0) begin failures++; $display("[TB] FAIL rst_count_discarded got=%h exp=%h", rd_d, 32'h0); end
        tick(1);
        checks++;
        if (rd_d !== 32'h0000_00FF) begin failures++; $display("[TB] FAIL rst_full_recount got=%h exp=%h", rd_d, 32'h0000_00FF); end
        address = 2'd3;
        tick(2);
        checks++;
        if (rd_d !== 32'h0000_00FF) begin failures++; $display("[TB] FAIL rst_release_edge got=%h exp=%h", rd_d, 32'h0000_00FF); end
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_d !== 32'h0) begin failures++; $display("[TB] FAIL rst_mask_cleared got=%h exp=%h", rd_d, 32'h0); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        address   = 2'd0;
        write_n   = 1'b1;
        writedata = 32'h0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        cs_c      = 1'b0;
        cs_d      = 1'b0;
        in_a      = 2'b00;
        in_b      = 2'b00;
        in_c      = 2'b00;
        in_d      = 32'h0;
        tick(2);
        reset_n = 1'b1;

        test_reset();
        test_bypass_rise();
        test_irq_clear();
        test_debounce();
        test_falling();
        test_any_width32();
        test_reset_mid_debounce();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
